// File: rtl/issue_rat_freelist_checkpoint_rr.sv
// Issue-stage RAT free-list checkpoint store.
// BANK_COUNT banks each hold up to BANK_DEPTH PRFs acquired under one FGR.
// A bank is released on commit, or drained on abandon/flush. Drained PRFs
// are returned through a round-robin arbiter across DRAIN banks.
module issue_rat_freelist_checkpoint_rr #(
    parameter int unsigned PRF_WIDTH  = 6,
    parameter int unsigned FGR_WIDTH  = 4,
    parameter int unsigned BANK_COUNT = 4,
    parameter int unsigned BANK_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 i_abandon_valid,
    input  logic [FGR_WIDTH-1:0]                 i_abandon_fgr,
    input  logic                                 i_commit_valid,
    input  logic [FGR_WIDTH-1:0]                 i_commit_fgr,
    input  logic                                 i_flush,
    output logic                                 o_abandoned_valid,
    input  logic                                 i_abandoned_ready,
    output logic [PRF_WIDTH-1:0]                 o_abandoned_prf,
    input  logic                                 i_acquired_valid,
    output logic                                 o_acquired_ready,
    input  logic [FGR_WIDTH-1:0]                 i_acquired_fgr,
    input  logic [PRF_WIDTH-1:0]                 i_acquired_prf,
    output logic [$clog2(BANK_COUNT+1)-1:0]      o_idle_count
);

    localparam int unsigned AW = $clog2(BANK_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned BW = $clog2(BANK_COUNT);
    localparam int unsigned CW = $clog2(BANK_COUNT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } bank_state_e;

    bank_state_e            state_q [BANK_COUNT];
    bank_state_e            state_d [BANK_COUNT];
    logic [FGR_WIDTH-1:0]   tag_q   [BANK_COUNT];
    logic [FGR_WIDTH-1:0]   tag_d   [BANK_COUNT];
    logic [PW-1:0]          wptr_q  [BANK_COUNT];
    logic [PW-1:0]          wptr_d  [BANK_COUNT];
    logic [PW-1:0]          rptr_q  [BANK_COUNT];
    logic [PW-1:0]          rptr_d  [BANK_COUNT];
    logic [BW-1:0]          rr_q;
    logic [BW-1:0]          rr_d;
    logic [PRF_WIDTH-1:0]   mem_q   [BANK_COUNT][BANK_DEPTH];

    logic [BANK_COUNT-1:0]  empty;
    logic [BANK_COUNT-1:0]  full;
    logic [BANK_COUNT-1:0]  match;
    logic                   has_match;
    logic                   has_idle;
    logic [BW-1:0]          match_idx;
    logic [BW-1:0]          idle_idx;
    logic [BW-1:0]          tgt_idx;
    logic                   acq_fire;
    logic                   sel_valid;
    logic [BW-1:0]          sel_idx;
    logic                   pop_fire;
    logic [CW-1:0]          idle_cnt;

    // Per-bank FIFO occupancy and acquire-tag match.
    always_comb begin
        for (int unsigned b = 0; b < BANK_COUNT; b++) begin
            empty[b] = (wptr_q[b] == rptr_q[b]);
            full[b]  = ((wptr_q[b] ^ rptr_q[b]) == {1'b1, {AW{1'b0}}});
            match[b] = (state_q[b] == S_ACTIVE) && (tag_q[b] == i_acquired_fgr);
        end
    end

    // Acquire target: matching ACTIVE bank, otherwise lowest-index IDLE bank.
    always_comb begin
        has_match = 1'b0;
        has_idle  = 1'b0;
        match_idx = '0;
        idle_idx  = '0;
        // Walk from the top so the lowest index is the one left standing.
        for (int unsigned i = 0; i < BANK_COUNT; i++) begin
            if (match[BANK_COUNT-1-i]) begin
                has_match = 1'b1;
                match_idx = BW'(BANK_COUNT-1-i);
            end
            if (state_q[BANK_COUNT-1-i] == S_IDLE) begin
                has_idle = 1'b1;
                idle_idx = BW'(BANK_COUNT-1-i);
            end
        end
        o_acquired_ready = has_match ? !full[match_idx] : has_idle;
        tgt_idx          = has_match ? match_idx : idle_idx;
        acq_fire         = i_acquired_valid && o_acquired_ready;
    end

    // Round-robin pick of the first non-empty DRAIN bank at or after rr.
    always_comb begin
        int unsigned j;
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < BANK_COUNT; i++) begin
            j = 32'(rr_q) + i;
            if (j >= BANK_COUNT) j = j - BANK_COUNT;
            if (!sel_valid && (state_q[j] == S_DRAIN) && !empty[j]) begin
                sel_valid = 1'b1;
                sel_idx   = BW'(j);
            end
        end
        pop_fire          = sel_valid && i_abandoned_ready;
        o_abandoned_valid = sel_valid;
        o_abandoned_prf   = sel_valid ? mem_q[sel_idx][rptr_q[sel_idx][AW-1:0]] : '0;
    end

    // Bank state transitions, pointer updates and arbiter pointer advance.
    always_comb begin
        rr_d = rr_q;
        for (int unsigned b = 0; b < BANK_COUNT; b++) begin
            state_d[b] = state_q[b];
            tag_d[b]   = tag_q[b];
            wptr_d[b]  = wptr_q[b];
            rptr_d[b]  = rptr_q[b];
            unique case (state_q[b])
                S_IDLE: begin
                    if (acq_fire && (tgt_idx == BW'(b))) begin
                        state_d[b] = S_ACTIVE;
                        tag_d[b]   = i_acquired_fgr;
                        wptr_d[b]  = wptr_q[b] + PW'(1);
                    end
                end
                S_ACTIVE: begin
                    // The push lands first; abandon/flush then keeps it for
                    // draining, while a commit clears it along with the bank.
                    if (acq_fire && (tgt_idx == BW'(b)))
                        wptr_d[b] = wptr_q[b] + PW'(1);
                    if (i_flush || (i_abandon_valid && (tag_q[b] == i_abandon_fgr))) begin
                        state_d[b] = S_DRAIN;
                    end else if (i_commit_valid && (tag_q[b] == i_commit_fgr)) begin
                        state_d[b] = S_IDLE;
                        wptr_d[b]  = '0;
                        rptr_d[b]  = '0;
                    end
                end
                S_DRAIN: begin
                    if (empty[b]) begin
                        state_d[b] = S_IDLE;
                        wptr_d[b]  = '0;
                        rptr_d[b]  = '0;
                    end else if (pop_fire && (sel_idx == BW'(b))) begin
                        rptr_d[b] = rptr_q[b] + PW'(1);
                        if ((rptr_q[b] + PW'(1)) == wptr_q[b]) begin
                            state_d[b] = S_IDLE;
                            wptr_d[b]  = '0;
                            rptr_d[b]  = '0;
                        end
                    end
                end
                default: state_d[b] = S_IDLE;
            endcase
        end
        if (pop_fire)
            rr_d = (sel_idx == BW'(BANK_COUNT-1)) ? '0 : sel_idx + BW'(1);
    end

    // Occupancy status for rename throttling.
    always_comb begin
        idle_cnt = '0;
        for (int unsigned b = 0; b < BANK_COUNT; b++)
            if (state_q[b] == S_IDLE) idle_cnt = idle_cnt + CW'(1);
        o_idle_count = idle_cnt;
    end

    // Register bank state, tags, pointers and the arbiter pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= '0;
            for (int unsigned b = 0; b < BANK_COUNT; b++) begin
                state_q[b] <= S_IDLE;
                tag_q[b]   <= '0;
                wptr_q[b]  <= '0;
                rptr_q[b]  <= '0;
            end
        end else begin
            rr_q <= rr_d;
            for (int unsigned b = 0; b < BANK_COUNT; b++) begin
                state_q[b] <= state_d[b];
                tag_q[b]   <= tag_d[b];
                wptr_q[b]  <= wptr_d[b];
                rptr_q[b]  <= rptr_d[b];
            end
        end
    end

    // PRF storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (acq_fire)
            mem_q[tgt_idx][wptr_q[tgt_idx][AW-1:0]] <= i_acquired_prf;
    end

endmodule
